// File: rtl/frame_strobe_sequencer_if.sv
// ---------------------------------------------------------------------------
// frame_strobe_sequencer_if
//
// Configuration word stream into the frame strobe sequencer.
//
// Handshake: a word transfers on every rising clock edge where in_valid and
// in_ready are both high. in_data is only meaningful on those edges; the
// source may change in_data / in_valid freely at any other time, and the
// sink may lower in_ready at any time without regard to in_valid.
//
// Signals:
//   in_data  [31:0]  configuration word (master -> slave)
//   in_valid         in_data holds a word (master -> slave)
//   in_ready         sink can take a word this cycle (slave -> master)
// ---------------------------------------------------------------------------
interface frame_strobe_sequencer_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// frame_strobe_sequencer
//
// Turns a header word plus a data word from the configuration stream into one
// frame write for a fabric tile column slot: FrameData_o is loaded, then after
// one setup cycle a one-hot FrameStrobe_o pulse of STROBE_CYCLES cycles is
// issued, followed by one hold cycle with the data still stable.
//
// Header word: [31:24] sync (must be 8'hA5), [23:16] frame index, [15:0] unused.
// A bad sync or an out-of-range index consumes the word and pulses err.
//
// Optional feature: define FRAME_ERR_CNT_EN to add err_count, a saturating
// 8-bit count of err pulses.
//
// Ports:
//   UserCLK        clock, all state changes on the rising edge
//   RST            asynchronous active-high reset
//   cfg            configuration word stream (slave side)
//   FrameData_o    frame data to the tile, holds between writes
//   FrameStrobe_o  one-hot frame strobe to the tile
//   busy           high whenever the sequencer is not idle
//   err            one-cycle pulse after a rejected header
//   err_count      saturating err pulse count (FRAME_ERR_CNT_EN only)
//   state_dbg      current state encoding, for observation only
// ---------------------------------------------------------------------------
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol = 8,
    parameter int FrameBitsPerRow = 8,
    parameter int STROBE_CYCLES   = 2
) (
    input  logic                       UserCLK,
    input  logic                       RST,
    frame_strobe_sequencer_if.slave    cfg,
    output logic [FrameBitsPerRow-1:0] FrameData_o,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_o,
    output logic                       busy,
    output logic                       err,
`ifdef FRAME_ERR_CNT_EN
    output logic [7:0]                 err_count,
`endif
    output logic [2:0]                 state_dbg
);

    localparam int IW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t                     state, state_next;
    logic [IW-1:0]              idx, idx_next;
    logic [CW-1:0]              cnt, cnt_next;
    logic [FrameBitsPerRow-1:0] data_next;
    logic                       err_next;

    logic accept;
    logic sync_ok;
    logic idx_ok;

    assign accept  = cfg.in_valid && cfg.in_ready;
    assign sync_ok = (cfg.in_data[31:24] == 8'hA5);
    assign idx_ok  = ({24'd0, cfg.in_data[23:16]} < 32'(MaxFramesPerCol));

    // Ready is a pure decode of the state so the source never sees a
    // combinational path from in_valid; it is also held low during reset.
    assign cfg.in_ready = !RST && ((state == S_IDLE) || (state == S_DATA));
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

    // Strobe is decoded from the state, so an asynchronous reset that
    // returns the state to IDLE drops it immediately.
    assign FrameStrobe_o = (state == S_STROBE) ? (MaxFramesPerCol'(1) << idx)
                                               : '0;

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            FrameData_o <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            cnt         <= cnt_next;
            FrameData_o <= data_next;
            err         <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        data_next  = FrameData_o;
        err_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (sync_ok && idx_ok) begin
                        idx_next   = cfg.in_data[16 +: IW];
                        state_next = S_DATA;
                    end else begin
                        // Rejected headers are consumed; stay idle.
                        err_next = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    data_next  = cfg.in_data[FrameBitsPerRow-1:0];
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                // Counter counts remaining strobe cycles after the current one.
                cnt_next   = CW'(STROBE_CYCLES - 1);
                state_next = S_STROBE;
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    state_next = S_HOLD;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef FRAME_ERR_CNT_EN
    // Counts alongside the err register so it reflects each pulse; sticks at 8'hFF.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            err_count <= '0;
        end else if (err_next && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_strobe_sequencer
//
// Self-checking bench for frame_strobe_sequencer (default parameters).
// Inputs change on the falling clock edge; outputs are sampled there too,
// half a cycle away from the active rising edge.
// Define FRAME_ERR_CNT_EN for both bench and design to cover err_count.
// ---------------------------------------------------------------------------
module tb_frame_strobe_sequencer;

    localparam int MF = 8;
    localparam int FB = 8;
    localparam int SC = 2;

    // ---------------- clock / reset ----------------
    logic user_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 user_clk = ~user_clk;

    int cyc = 0;
    always @(posedge user_clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    frame_strobe_sequencer_if cfg();

    logic [FB-1:0] frame_data;
    logic [MF-1:0] frame_strobe;
    logic          busy;
    logic          err;
    logic [2:0]    state_dbg;
`ifdef FRAME_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    frame_strobe_sequencer dut (
        .UserCLK       (user_clk),
        .RST           (rst),
        .cfg           (cfg),
        .FrameData_o   (frame_data),
        .FrameStrobe_o (frame_strobe),
        .busy          (busy),
        .err           (err),
`ifdef FRAME_ERR_CNT_EN
        .err_count     (err_count),
`endif
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard / model state ----------------
    int            vectors     = 0;
    int            miscompares = 0;
    logic [FB-1:0] m_fd        = '0;  // last value written to FrameData_o
    int            m_errcnt    = 0;   // err pulses since reset, saturating at 255
    int            last_strobe_cyc = 0;
    logic [MF-1:0] exp_q[$];          // expected strobe per cycle after a data accept

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] d);
        cfg.in_valid = v;
        cfg.in_data  = d;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_ready"},  32'(cfg.in_ready), 32'd1);
        check({tag, "_strobe"}, 32'(frame_strobe), 32'd0);
        check({tag, "_fd"},     32'(frame_data), 32'(m_fd));
    endtask

    // Idle cycles with garbage data and valid low.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, $urandom);
            @(negedge user_clk);
            check_idle("idle");
            check("idle_err", 32'(err), 32'd0);
`ifdef FRAME_ERR_CNT_EN
            check("idle_err_count", 32'(err_count), 32'(m_errcnt));
`endif
        end
    endtask

    // Offer a header that must be rejected; returns at the negedge where err is high.
    task automatic do_bad(input logic [31:0] w);
        check_idle("bad_pre");
        drive(1'b1, w);
        @(negedge user_clk);
        if (m_errcnt < 255) m_errcnt++;
        check("bad_err",    32'(err), 32'd1);
        check("bad_busy",   32'(busy), 32'd0);
        check("bad_strobe", 32'(frame_strobe), 32'd0);
        check("bad_ready",  32'(cfg.in_ready), 32'd1);
        drive(1'b0, $urandom);
    endtask

    // One full frame write from IDLE back to IDLE. keep_valid holds in_valid
    // high with garbage while the sequencer is not ready; data_gap inserts
    // cycles without valid in DATA; abort asserts RST in the first strobe cycle.
    task automatic do_frame(input logic [31:0] h, input logic [31:0] d,
                            input bit keep_valid, input int data_gap, input bit abort);
        int            idx;
        logic [MF-1:0] one_hot;
        logic [MF-1:0] exp_s;
        idx     = int'(h[23:16]);
        one_hot = '0;
        one_hot[idx] = 1'b1;

        check_idle("hdr_pre");
        drive(1'b1, h);
        @(negedge user_clk);
        check("data_busy",   32'(busy), 32'd1);
        check("data_ready",  32'(cfg.in_ready), 32'd1);
        check("data_strobe", 32'(frame_strobe), 32'd0);
        check("data_err",    32'(err), 32'd0);
        check("data_fd",     32'(frame_data), 32'(m_fd));
        for (int g = 0; g < data_gap; g++) begin
            drive(1'b0, $urandom);
            @(negedge user_clk);
            check("wait_busy",  32'(busy), 32'd1);
            check("wait_ready", 32'(cfg.in_ready), 32'd1);
            check("wait_fd",    32'(frame_data), 32'(m_fd));
        end
        drive(1'b1, d);
        m_fd = d[FB-1:0];

        // Setup cycle, SC strobe cycles, hold cycle, then idle.
        for (int k = 0; k <= SC + 2; k++) begin
            exp_q.push_back((k >= 1 && k <= SC) ? one_hot : '0);
        end

        for (int k = 0; k <= SC + 2; k++) begin
            @(negedge user_clk);
            if (k == 0) drive(keep_valid, $urandom);
            exp_s = exp_q.pop_front();
            check("seq_strobe", 32'(frame_strobe), 32'(exp_s));
            check("seq_fd",     32'(frame_data), 32'(m_fd));
            check("seq_busy",   32'(busy), (k <= SC + 1) ? 32'd1 : 32'd0);
            check("seq_ready",  32'(cfg.in_ready), (k == SC + 2) ? 32'd1 : 32'd0);
            if (k == 1) last_strobe_cyc = cyc;
            if (abort && k == 1) begin
                #2;
                rst = 1'b1;
                drive(1'b0, $urandom);
                #1;
                m_fd     = '0;
                m_errcnt = 0;
                exp_q.delete();
                check("abort_strobe", 32'(frame_strobe), 32'd0);
                check("abort_fd",     32'(frame_data), 32'd0);
                check("abort_busy",   32'(busy), 32'd0);
                check("abort_ready",  32'(cfg.in_ready), 32'd0);
                check("abort_err",    32'(err), 32'd0);
                @(negedge user_clk);
                check("abort_hold_strobe", 32'(frame_strobe), 32'd0);
                rst = 1'b0;
                #1;
                check("abort_rel_ready", 32'(cfg.in_ready), 32'd1);
                check("abort_rel_busy",  32'(busy), 32'd0);
                @(negedge user_clk);
                return;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        int s1;
        drive(1'b0, 32'd0);
        rst = 1'b1;
        @(negedge user_clk);
        @(negedge user_clk);
        check("rst_ready",  32'(cfg.in_ready), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_strobe", 32'(frame_strobe), 32'd0);
        check("rst_fd",     32'(frame_data), 32'd0);
        check("rst_err",    32'(err), 32'd0);
`ifdef FRAME_ERR_CNT_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif
        rst = 1'b0;
        @(negedge user_clk);
        check_idle("post_rst");

        // Basic frame: index 3, data C3.
        do_frame(32'hA503_0000, 32'h0000_00C3, 1'b0, 0, 1'b0);
        idle(1);

        // Bad sync, then a good header immediately.
        do_bad(32'h5A01_0000);
        do_frame(32'hA501_1234, 32'h0000_005A, 1'b0, 0, 1'b0);

        // Out-of-range index; the next word is a header (bad sync here), not data.
        do_bad(32'hA509_0000);
        do_bad(32'h0000_00C3);
        do_frame(32'hA502_0000, 32'h0000_0077, 1'b0, 1, 1'b0);

        // Back-to-back frames 0 and 7 with in_valid held high.
        do_frame(32'hA500_0000, 32'h0000_0011, 1'b1, 0, 1'b0);
        s0 = last_strobe_cyc;
        do_frame(32'hA507_0000, 32'h0000_0022, 1'b1, 0, 1'b0);
        s1 = last_strobe_cyc;
        check("strobe_gap", 32'(s1 - s0), 32'(SC + 4));
        idle(1);

        // Reset during the first strobe cycle.
        do_frame(32'hA504_0000, 32'h0000_00A5, 1'b0, 0, 1'b1);
        idle(1);

        // Randomized mix of good frames, bad headers and idle gaps.
        for (int n = 0; n < 40; n++) begin
            int            r;
            logic [7:0]    b;
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                do_bad({b, 24'($urandom)});
            end else if (r == 2) begin
                b = 8'($urandom_range(MF, 255));
                do_bad({8'hA5, b, 16'($urandom)});
            end else if (r == 3) begin
                idle($urandom_range(1, 3));
            end else begin
                b = 8'($urandom_range(0, MF - 1));
                do_frame({8'hA5, b, 16'($urandom)}, $urandom,
                         1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
            end
        end
        idle(1);

`ifdef FRAME_ERR_CNT_EN
        // Saturation of the error counter.
        rst = 1'b1;
        #1;
        m_errcnt = 0;
        check("cnt_rst0", 32'(err_count), 32'd0);
        @(negedge user_clk);
        rst = 1'b0;
        @(negedge user_clk);
        for (int i = 0; i < 10; i++) do_bad(32'h0000_0000);
        idle(1);
        for (int i = 0; i < 290; i++) do_bad(32'h1234_5678);
        idle(2);
        check("cnt_sat", 32'(err_count), 32'hFF);
        rst = 1'b1;
        #1;
        m_errcnt = 0;
        check("cnt_rst", 32'(err_count), 32'd0);
        @(negedge user_clk);
        rst = 1'b0;
        @(negedge user_clk);
        idle(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
